// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: reset level, zero word,
// stall freeze-vector encodings, FSM state codes and the stall priority encoder.
package pipe_ctrl_pkg;

  // Reset level and common constants
  localparam logic        RstEnable  = 1'b1;
  localparam logic        RstDisable = 1'b0;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;

  // Freeze vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
  // A stalled stage also freezes every stage upstream of it.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  // Controller states: normal running, waiting for the data bus to go idle
  // before redirecting, and the single redirect/flush cycle.
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  // Priority encoder for stall requests: the most downstream requester wins,
  // since its freeze pattern covers all upstream stages anyway.
  function automatic logic [5:0] stall_encode(
    input logic req_if,
    input logic req_id,
    input logic req_ex,
    input logic req_mem
  );
    logic [5:0] v;
    if (req_mem) begin
      v = STALL_MEM;
    end else if (req_ex) begin
      v = STALL_EX;
    end else if (req_id) begin
      v = STALL_ID;
    end else if (req_if) begin
      v = STALL_IF;
    end else begin
      v = STALL_NONE;
    end
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the stalled-cycle performance counter.
// Clear wins over increment; the count sticks at all-ones.
module sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  // Next count: clear first, then saturating increment, else hold
  always_comb begin
    w_cnt_next = r_cnt;
    if (clr) begin
      w_cnt_next = CNT_ZERO;
    end else if (inc && (r_cnt != CNT_MAX)) begin
      w_cnt_next = r_cnt + CNT_ONE;
    end else begin
      w_cnt_next = r_cnt;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_cnt <= CNT_ZERO;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller. Merges per-stage stall requests into a
// freeze vector, sequences precise exceptions (optionally draining an
// outstanding data-bus access first) into a one-cycle flush with redirect,
// and counts cycles in which the PC is frozen.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             excp_valid,
  input  logic [31:0]      excp_pc,
  input  logic             bus_busy,
  input  logic             cnt_clr,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e      r_state;
  state_e      w_next_state;
  logic [31:0] r_excp_pc;
  logic [31:0] r_new_pc;
  logic        r_flush;
  logic [5:0]  w_stall;
  logic [5:0]  w_stall_fsm;
  logic        w_latch_pc;
  logic [31:0] w_redirect_pc;
  logic        w_enter_flush;

  // Next-state and freeze-vector decode; an exception in RUN freezes the whole
  // pipe and captures its handler address in the same cycle
  always_comb begin
    w_next_state  = r_state;
    w_stall_fsm   = STALL_NONE;
    w_latch_pc    = 1'b0;
    w_redirect_pc = r_excp_pc;
    case (r_state)
      ST_RUN: begin
        if (excp_valid) begin
          w_stall_fsm   = STALL_ALL;
          w_latch_pc    = 1'b1;
          w_redirect_pc = excp_pc;
          if (bus_busy) begin
            w_next_state = ST_DRAIN;
          end else begin
            w_next_state = ST_FLUSH;
          end
        end else begin
          w_stall_fsm  = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
          w_next_state = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Further exceptions are ignored here: the first one owns the redirect
        w_stall_fsm = STALL_ALL;
        if (bus_busy) begin
          w_next_state = ST_DRAIN;
        end else begin
          w_next_state = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_stall_fsm  = STALL_NONE;
        w_next_state = ST_RUN;
      end
      default: begin
        // Unreachable encoding: recover to RUN without freezing anything
        w_stall_fsm  = STALL_NONE;
        w_next_state = ST_RUN;
      end
    endcase
  end

  // Freeze vector is forced clear while reset is held
  always_comb begin
    w_stall = STALL_NONE;
    if (rst == RstEnable) begin
      w_stall = STALL_NONE;
    end else begin
      w_stall = w_stall_fsm;
    end
  end

  assign w_enter_flush = (w_next_state == ST_FLUSH);

  // State, exception-address latch and registered flush/redirect outputs;
  // reset in DRAIN or FLUSH simply returns to RUN, so no flush follows
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state   <= ST_RUN;
      r_excp_pc <= ZeroWord;
      r_new_pc  <= ZeroWord;
      r_flush   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_flush <= w_enter_flush;
      if (w_latch_pc) begin
        r_excp_pc <= excp_pc;
      end
      if (w_enter_flush) begin
        r_new_pc <= w_redirect_pc;
      end
    end
  end

  // Stalled-cycle counter: counts every cycle in which the PC is frozen
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stall[0]),
    .clr (cnt_clr),
    .cnt (stall_cnt)
  );

  assign stall  = w_stall;
  assign flush  = r_flush;
  assign new_pc = r_new_pc;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pipe_ctrl;

  localparam int TB_CNT_W = 4;

  logic                clk;
  logic                rst;
  logic                stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic                excp_valid;
  logic [31:0]         excp_pc;
  logic                bus_busy;
  logic                cnt_clr;
  logic [5:0]          stall;
  logic                flush;
  logic [31:0]         new_pc;
  logic [TB_CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excp_valid   (excp_valid),
    .excp_pc      (excp_pc),
    .bus_busy     (bus_busy),
    .cnt_clr      (cnt_clr),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_pending: an exception is accepted and waiting for the bus to go idle
  // m_flush  : flush pulse visible this cycle
  logic                m_ready = 1'b0;
  logic                m_pending, m_flush;
  logic [31:0]         m_pc, m_newpc;
  logic [TB_CNT_W-1:0] m_cnt;

  function automatic logic [5:0] exp_stall();
    if (rst)                      return 6'b000000;
    if (m_flush)                  return 6'b000000;
    if (m_pending || excp_valid)  return 6'b111111;
    if (stallreq_mem)             return 6'b011111;
    if (stallreq_ex)              return 6'b001111;
    if (stallreq_id)              return 6'b000111;
    if (stallreq_if)              return 6'b000011;
    return 6'b000000;
  endfunction

  always @(posedge clk) begin
    logic [5:0] s;
    logic       accept, busy_exc;
    s = exp_stall();
    if (rst) begin
      m_pending <= 1'b0;
      m_flush   <= 1'b0;
      m_pc      <= 32'h0;
      m_newpc   <= 32'h0;
      m_cnt     <= '0;
      m_ready   <= 1'b1;
    end else begin
      accept   = excp_valid && !m_pending && !m_flush;
      busy_exc = accept || m_pending;
      if (accept) m_pc <= excp_pc;
      m_pending <= busy_exc && bus_busy;
      m_flush   <= busy_exc && !bus_busy;
      if (busy_exc && !bus_busy) m_newpc <= accept ? excp_pc : m_pc;
      if (cnt_clr)                        m_cnt <= '0;
      else if (s[0] && (m_cnt != 4'hF))   m_cnt <= m_cnt + 4'd1;
    end
  end

  // Compare process: every cycle once reset has been applied
  always @(negedge clk) begin
    if (m_ready) begin
      chk("model_stall", {26'd0, stall}, {26'd0, exp_stall()});
      chk("model_flush", {31'd0, flush}, {31'd0, m_flush});
      chk("model_cnt",   {28'd0, stall_cnt}, {28'd0, m_cnt});
      if (m_flush) chk("model_new_pc", new_pc, m_newpc);
    end
  end

  // ---------------- stimulus ----------------
  // req = {mem, ex, id, if}; inputs change just after the rising edge and
  // the task returns at the falling edge so the caller can check outputs
  task automatic drv(input logic [3:0] req, input logic ex, input logic [31:0] pc,
                     input logic busy, input logic clr, input logic r);
    @(posedge clk);
    #1;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    excp_valid = ex;
    excp_pc    = pc;
    bus_busy   = busy;
    cnt_clr    = clr;
    rst        = r;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0000;
    excp_valid = 1'b0; excp_pc = 32'h0; bus_busy = 1'b0; cnt_clr = 1'b0;

    // Reset, with a stall request held to show stall is forced clear
    drv(4'b1000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    drv(4'b1000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_stall", {26'd0, stall}, 32'h0);
    drv(4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_flush",  {31'd0, flush}, 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_cnt",    {28'd0, stall_cnt}, 32'h0);

    // Stall priority patterns
    drv(4'b0001, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("prio_if", {26'd0, stall}, 32'h03);
    drv(4'b0010, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("prio_id", {26'd0, stall}, 32'h07);
    drv(4'b0100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("prio_ex", {26'd0, stall}, 32'h0F);
    drv(4'b1000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("prio_mem", {26'd0, stall}, 32'h1F);
    drv(4'b1010, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("id_mem_stall", {26'd0, stall}, 32'h1F);
    chk("id_mem_cnt_before", {28'd0, stall_cnt}, 32'd4);
    drv(4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("id_mem_cnt_after", {28'd0, stall_cnt}, 32'd5);
    drv(4'b0000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drv(4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("clr_cnt", {28'd0, stall_cnt}, 32'd0);

    // Exception with bus idle: flush exactly one cycle later
    drv(4'b1000, 1'b1, 32'hBFC00380, 1'b0, 1'b0, 1'b0);
    chk("exc_stall_N", {26'd0, stall}, 32'h3F);
    chk("exc_flush_N", {31'd0, flush}, 32'h0);
    drv(4'b0100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("exc_flush_N1", {31'd0, flush}, 32'h1);
    chk("exc_new_pc_N1", new_pc, 32'hBFC00380);
    chk("exc_stall_N1", {26'd0, stall}, 32'h0);
    drv(4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("exc_flush_N2", {31'd0, flush}, 32'h0);
    chk("exc_stall_N2", {26'd0, stall}, 32'h0);

    // Exception with bus busy 3 cycles, second exception during DRAIN
    drv(4'b0000, 1'b1, 32'hBFC00380, 1'b1, 1'b0, 1'b0);
    chk("drain_stall0", {26'd0, stall}, 32'h3F);
    drv(4'b0000, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b0);
    chk("drain_stall1", {26'd0, stall}, 32'h3F);
    drv(4'b0000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("drain_stall2", {26'd0, stall}, 32'h3F);
    drv(4'b0001, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("drain_stall3", {26'd0, stall}, 32'h3F);
    chk("drain_noflush", {31'd0, flush}, 32'h0);
    // Exception presented during the FLUSH cycle must be ignored too
    drv(4'b0000, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0);
    chk("drain_flush", {31'd0, flush}, 32'h1);
    chk("drain_new_pc", new_pc, 32'hBFC00380);
    drv(4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("drain_after_flush", {31'd0, flush}, 32'h0);
    chk("drain_after_stall", {26'd0, stall}, 32'h0);
    drv(4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("flush_excp_ignored", {31'd0, flush}, 32'h0);

    // Saturation: count up to 4'hE, then three EX stalls, then clear
    drv(4'b0000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) drv(4'b0001, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drv(4'b0100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_preload", {28'd0, stall_cnt}, 32'hE);
    drv(4'b0100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_reach", {28'd0, stall_cnt}, 32'hF);
    drv(4'b0100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_hold1", {28'd0, stall_cnt}, 32'hF);
    drv(4'b0100, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("sat_hold2", {28'd0, stall_cnt}, 32'hF);
    drv(4'b0100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_clr", {28'd0, stall_cnt}, 32'h0);

    // Reset while draining aborts the exception
    drv(4'b0000, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b0);
    drv(4'b0000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("abort_drain_stall", {26'd0, stall}, 32'h3F);
    drv(4'b0000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("abort_rst_stall", {26'd0, stall}, 32'h0);
    drv(4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("abort_flush0", {31'd0, flush}, 32'h0);
    chk("abort_cnt", {28'd0, stall_cnt}, 32'h0);
    chk("abort_stall", {26'd0, stall}, 32'h0);
    drv(4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("abort_flush1", {31'd0, flush}, 32'h0);
    drv(4'b0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("abort_flush2", {31'd0, flush}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
